// File: rtl/xor_stream_pkg.sv
// Shared constants, state encoding and LFSR step for the XOR stream descrambler.
// Keystream polynomial is x^20+x^17+1 in Fibonacci form.
package xor_stream_pkg;

  localparam int unsigned WIDTH_C = 20;
  localparam logic [WIDTH_C-1:0] DEF_SEED_C = 20'hFFFFF;
  localparam int unsigned TAP_HI = 19;
  localparam int unsigned TAP_LO = 16;

  typedef enum logic {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } state_t;

  function automatic logic [WIDTH_C-1:0] lfsr_next(
    input logic [WIDTH_C-1:0] k
  );
    logic fb;
    fb = k[TAP_HI] ^ k[TAP_LO];
    return {k[WIDTH_C-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_keygen.sv
// Keystream register: seed load with zero-seed substitution, advance per word.
// Load wins over advance; the top never asserts both together.
module lfsr_keygen
  import xor_stream_pkg::*;
#(
  parameter logic [WIDTH_C-1:0] DEF_SEED = DEF_SEED_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH_C-1:0] seed,
  input  logic               adv,
  output logic [WIDTH_C-1:0] key,
  output logic               seed_err
);

  logic seed_zero;

  assign seed_zero = (seed == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key      <= DEF_SEED;
      seed_err <= 1'b0;
    end else begin
      seed_err <= load && seed_zero;
      if (load) begin
        key <= seed_zero ? DEF_SEED : seed;
      end else if (adv) begin
        key <= lfsr_next(key);
      end
    end
  end

endmodule

// File: rtl/xor_stream_descrambler.sv
// XOR stream descrambler: plaintext = in_data ^ keystream, registered output.
// Optional WORD_CNT_EN adds a 16-bit accepted-word counter port.
module xor_stream_descrambler
  import xor_stream_pkg::*;
#(
  parameter int unsigned       WIDTH    = WIDTH_C,
  parameter logic [WIDTH-1:0]  DEF_SEED = DEF_SEED_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             seeded,
  output logic             seed_err
`ifdef WORD_CNT_EN
  ,
  output logic [15:0]      word_cnt
`endif
);

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] key;

  assign in_ready = (state == RUN) && !seed_load
                 && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  lfsr_keygen #(
    .DEF_SEED (DEF_SEED)
  ) u_keygen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .seed     (seed),
    .adv      (accept),
    .key      (key),
    .seed_err (seed_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= UNSEEDED;
      seeded <= 1'b0;
    end else if (seed_load) begin
      state  <= RUN;
      seeded <= 1'b1;
    end
  end

  // Word in flight is dropped on reset; reseeding leaves it to drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ key;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef WORD_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || seed_load) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule
